display_arbiter: RTL and testbench

Shares the single 4-digit 7-segment display driver between up to `N_REQ` requesters, such as the fault indicator, the debugger view and the default PC/bus view. It grants the display to one requester at a time by fixed priority and enforces a minimum dwell so the owner cannot flicker. Ownership changes use a luminance fade-out/fade-in ramp. It sits directly upstream of the display driver and drives its `en`, `luminance`, `hexx` and `points` inputs.

---
 rtl/display_arbiter_pkg.sv | 16 +
 rtl/display_arbiter_if.sv | 25 ++
 rtl/display_arbiter_prio_pick.sv | 25 ++
 rtl/display_arbiter.sv | 156 +++++++++++++++
 tb/tb_display_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the display arbiter slice.
// Pure declarations: no logic, no latency, no flow control.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    SHOW     = 2'd2,
    FADE_OUT = 2'd3
  } disp_state_t;

  localparam logic [3:0] LUM_MAX = 4'hF;
  localparam int DIGIT_W = 16;
  localparam int POINT_W = 4;

endpackage

// File: rtl/display_arbiter_if.sv
// Requester-side and driver-side signals of the display arbiter.
// master = requesters/bench side, slave = arbiter side; level requests, no backpressure.
interface display_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]                      req;
  logic [display_pkg::DIGIT_W*N_REQ-1:0] req_hexx;
  logic [display_pkg::POINT_W*N_REQ-1:0] req_points;
  logic [3:0]                            max_lum;
  logic [N_REQ-1:0]                      gnt;
  logic                                  disp_en;
  logic [3:0]                            disp_luminance;
  logic [display_pkg::DIGIT_W-1:0]       disp_hexx;
  logic [display_pkg::POINT_W-1:0]       disp_points;

  modport master (
    output req, req_hexx, req_points, max_lum,
    input  gnt, disp_en, disp_luminance, disp_hexx, disp_points
  );

  modport slave (
    input  req, req_hexx, req_points, max_lum,
    output gnt, disp_en, disp_luminance, disp_hexx, disp_points
  );
endinterface

// File: rtl/display_arbiter_prio_pick.sv
// Lowest-index-first one-hot picker with binary index of the winner.
// Purely combinational (0 cycles); no flow control.
module prio_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Fixed-priority owner of the 7-segment driver with dwell hold and luminance fades.
// Registered outputs, grant one cycle after req; level requests, requesters hold req until gnt.
module display_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ            = 3,
  parameter int HOLD_CYCLES      = 1_000_000,
  parameter int FADE_STEP_CYCLES = 65_536
) (
  input logic           clk,
  input logic           rst_n,
  display_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam int DW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(FADE_STEP_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(HOLD_CYCLES);

  disp_state_t          state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 en_q, en_d;
  logic [3:0]           lum_q, lum_d;
  logic [DIGIT_W-1:0]   hexx_q, hexx_d;
  logic [POINT_W-1:0]   points_q, points_d;
  logic [SW-1:0]        step_q, step_d;
  logic [DW-1:0]        dwell_q, dwell_d;

  logic [N_REQ-1:0]     pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_vld;
  logic                 hi_req;
  logic                 owner_req;
  logic                 step_done;
  logic [IW-1:0]        sel;
  logic [DIGIT_W-1:0]   sel_hexx;
  logic [POINT_W-1:0]   sel_points;

  prio_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // The lowest pending index is below the owner exactly when some higher-priority req is up.
  assign pick_vld  = |pick_onehot;
  assign hi_req    = pick_vld && (pick_idx < owner_q);
  assign owner_req = bus.req[owner_q];
  assign step_done = (step_q == STEP_LAST);

  assign sel        = (state_q == IDLE) ? pick_idx : owner_q;
  assign sel_hexx   = bus.req_hexx[DIGIT_W*sel +: DIGIT_W];
  assign sel_points = bus.req_points[POINT_W*sel +: POINT_W];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    en_d     = en_q;
    lum_d    = lum_q;
    hexx_d   = hexx_q;
    points_d = points_q;
    step_d   = step_q;
    dwell_d  = dwell_q;

    // Content follows the owner while it still asks; otherwise it freezes.
    if ((state_q == IDLE && pick_vld) || (state_q != IDLE && owner_req)) begin
      hexx_d   = sel_hexx;
      points_d = sel_points;
    end

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = FADE_IN;
          owner_d = pick_idx;
          gnt_d   = pick_onehot;
          en_d    = 1'b1;
          lum_d   = 4'd0;
          step_d  = '0;
        end
      end
      FADE_IN: begin
        if (!owner_req) begin
          state_d = FADE_OUT;
          step_d  = '0;
        end else if (lum_q >= bus.max_lum) begin
          state_d = SHOW;
          lum_d   = bus.max_lum;
          dwell_d = '0;
        end else if (step_done) begin
          step_d = '0;
          lum_d  = (lum_q == LUM_MAX) ? lum_q : lum_q + 4'd1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      SHOW: begin
        lum_d = bus.max_lum;
        if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
        if (!owner_req || (dwell_q == DWELL_MAX && hi_req)) begin
          state_d = FADE_OUT;
          step_d  = '0;
        end
      end
      FADE_OUT: begin
        if (step_done) begin
          step_d = '0;
          if (lum_q == 4'd0) begin
            state_d = IDLE;
            gnt_d   = '0;
            en_d    = 1'b0;
          end else begin
            lum_d = lum_q - 4'd1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      gnt_q    <= '0;
      en_q     <= 1'b0;
      lum_q    <= 4'd0;
      hexx_q   <= '0;
      points_q <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      en_q     <= en_d;
      lum_q    <= lum_d;
      hexx_q   <= hexx_d;
      points_q <= points_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.disp_en        = en_q;
  assign bus.disp_luminance = lum_q;
  assign bus.disp_hexx      = hexx_q;
  assign bus.disp_points    = points_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with short fade step (4) and hold (20).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_display_arbiter;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  display_arbiter_if #(.N_REQ(3)) bus ();

  display_arbiter #(
    .N_REQ            (3),
    .HOLD_CYCLES      (20),
    .FADE_STEP_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b want=000", bus.gnt); end
    total++; if (bus.disp_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", bus.disp_en); end
    total++; if (bus.disp_luminance !== 4'd0) begin bad++; $display("FAIL reset_lum got=%0d want=0", bus.disp_luminance); end
    total++; if (bus.disp_hexx !== 16'h0000) begin bad++; $display("FAIL reset_hexx got=%h want=0000", bus.disp_hexx); end
    total++; if (bus.disp_points !== 4'h0) begin bad++; $display("FAIL reset_points got=%h want=0", bus.disp_points); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.gnt !== 3'b000 || bus.disp_en !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset gnt=%b en=%b want 000/0", bus.gnt, bus.disp_en);
    end
  endtask

  // Owner 2 fades in 0->3 at one step per 4 cycles, then SHOW.
  task automatic test_single_grant;
    logic [3:0] el;
    total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL pre_grant got=%b want=000", bus.gnt); end
    bus.req = 3'b100;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      el = 4'((i - 1) / 4);
      total++; if (bus.gnt !== 3'b100 || bus.disp_en !== 1'b1) begin
        bad++; $display("FAIL single_gnt i=%0d gnt=%b en=%b want 100/1", i, bus.gnt, bus.disp_en);
      end
      total++; if (bus.disp_luminance !== el) begin
        bad++; $display("FAIL single_lum i=%0d got=%0d want=%0d", i, bus.disp_luminance, el);
      end
      if (i == 1) begin
        total++; if (bus.disp_hexx !== 16'hABCD) begin bad++; $display("FAIL single_hexx got=%h want=abcd", bus.disp_hexx); end
        total++; if (bus.disp_points !== 4'h5) begin bad++; $display("FAIL single_points got=%h want=5", bus.disp_points); end
      end
      if (i == 6) bus.req_hexx[47:32] = 16'h1234;
      if (i == 7) begin
        total++; if (bus.disp_hexx !== 16'h1234) begin bad++; $display("FAIL track_hexx got=%h want=1234", bus.disp_hexx); end
      end
    end
  endtask

  // req[0] rises at dwell 5; preemption waits until dwell 20, then fade 3->0 and grant 0.
  task automatic test_preempt;
    logic [2:0] eg;
    logic [3:0] el;
    logic       ee;
    repeat (3) @(negedge clk);
    bus.req = 3'b101;
    for (int i = 20; i <= 52; i++) begin
      @(negedge clk);
      eg = (i <= 50) ? 3'b100 : ((i == 51) ? 3'b000 : 3'b001);
      ee = (i != 51);
      if (i <= 38)      el = 4'd3;
      else if (i <= 42) el = 4'd2;
      else if (i <= 46) el = 4'd1;
      else              el = 4'd0;
      total++; if (bus.gnt !== eg) begin bad++; $display("FAIL preempt_gnt i=%0d got=%b want=%b", i, bus.gnt, eg); end
      total++; if (bus.disp_en !== ee) begin bad++; $display("FAIL preempt_en i=%0d got=%b want=%b", i, bus.disp_en, ee); end
      total++; if (bus.disp_luminance !== el) begin
        bad++; $display("FAIL preempt_lum i=%0d got=%0d want=%0d", i, bus.disp_luminance, el);
      end
    end
    total++; if (bus.disp_hexx !== 16'h1111) begin bad++; $display("FAIL preempt_hexx got=%h want=1111", bus.disp_hexx); end
  endtask

  // Owner 0 keeps the display against req[2]; releasing it hands over to 2.
  task automatic test_no_lower_preempt;
    logic [2:0] eg;
    logic [3:0] el;
    for (int i = 53; i <= 100; i++) begin
      @(negedge clk);
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL hold_gnt i=%0d got=%b want=001", i, bus.gnt); end
    end
    total++; if (bus.disp_luminance !== 4'd3) begin bad++; $display("FAIL hold_lum got=%0d want=3", bus.disp_luminance); end
    bus.req = 3'b100;
    bus.req_hexx[15:0] = 16'h9999;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      eg = (k <= 16) ? 3'b001 : ((k == 17) ? 3'b000 : 3'b100);
      total++; if (bus.gnt !== eg) begin bad++; $display("FAIL release_gnt k=%0d got=%b want=%b", k, bus.gnt, eg); end
      if (k <= 16) begin
        el = 4'd3 - 4'((k - 1) / 4);
        total++; if (bus.disp_luminance !== el) begin
          bad++; $display("FAIL release_lum k=%0d got=%0d want=%0d", k, bus.disp_luminance, el);
        end
        total++; if (bus.disp_hexx !== 16'h1111) begin
          bad++; $display("FAIL release_freeze k=%0d got=%h want=1111", k, bus.disp_hexx);
        end
      end
    end
    total++; if (bus.disp_hexx !== 16'h1234) begin bad++; $display("FAIL handover_hexx got=%h want=1234", bus.disp_hexx); end
  endtask

  // Owner 2 drops at luminance 2 mid fade-in: fade out from 2, gnt clears 12 cycles later.
  task automatic test_drop_fade_in;
    logic [2:0] eg;
    logic [3:0] el;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k >= 8) begin
        total++; if (bus.disp_luminance !== 4'd2) begin
          bad++; $display("FAIL fadein_lum k=%0d got=%0d want=2", k, bus.disp_luminance);
        end
      end
    end
    bus.req = 3'b000;
    bus.req_hexx[47:32] = 16'h5678;
    for (int k = 10; k <= 22; k++) begin
      @(negedge clk);
      eg = (k <= 21) ? 3'b100 : 3'b000;
      if (k <= 13)      el = 4'd2;
      else if (k <= 17) el = 4'd1;
      else              el = 4'd0;
      total++; if (bus.gnt !== eg) begin bad++; $display("FAIL drop_gnt k=%0d got=%b want=%b", k, bus.gnt, eg); end
      total++; if (bus.disp_luminance !== el) begin
        bad++; $display("FAIL drop_lum k=%0d got=%0d want=%0d", k, bus.disp_luminance, el);
      end
      total++; if (bus.disp_hexx !== 16'h1234) begin bad++; $display("FAIL drop_freeze k=%0d got=%h want=1234", k, bus.disp_hexx); end
    end
  endtask

  // max_lum=0 makes FADE_IN a single cycle; SHOW then follows max_lum next cycle.
  task automatic test_max_lum;
    bus.max_lum = 4'd0;
    bus.req = 3'b010;
    @(negedge clk);
    total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL lum0_gnt got=%b want=010", bus.gnt); end
    total++; if (bus.disp_hexx !== 16'h2222 || bus.disp_points !== 4'h2) begin
      bad++; $display("FAIL lum0_data got=%h/%h want=2222/2", bus.disp_hexx, bus.disp_points);
    end
    @(negedge clk);
    total++; if (bus.disp_luminance !== 4'd0) begin bad++; $display("FAIL lum0_show got=%0d want=0", bus.disp_luminance); end
    bus.max_lum = 4'd5;
    @(negedge clk);
    total++; if (bus.disp_luminance !== 4'd5) begin bad++; $display("FAIL lum_follow5 got=%0d want=5", bus.disp_luminance); end
    bus.max_lum = 4'd9;
    @(negedge clk);
    total++; if (bus.disp_luminance !== 4'd9) begin bad++; $display("FAIL lum_follow9 got=%0d want=9", bus.disp_luminance); end
  endtask

  // Reset dropped between clock edges during FADE_OUT clears outputs at once.
  task automatic test_async_reset;
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
    total++; if (bus.disp_luminance !== 4'd9 || bus.disp_en !== 1'b1 || bus.gnt !== 3'b010) begin
      bad++; $display("FAIL fadeout_state lum=%0d en=%b gnt=%b want 9/1/010", bus.disp_luminance, bus.disp_en, bus.gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL areset_gnt got=%b want=000", bus.gnt); end
    total++; if (bus.disp_en !== 1'b0) begin bad++; $display("FAIL areset_en got=%b want=0", bus.disp_en); end
    total++; if (bus.disp_luminance !== 4'd0) begin bad++; $display("FAIL areset_lum got=%0d want=0", bus.disp_luminance); end
    total++; if (bus.disp_hexx !== 16'h0000) begin bad++; $display("FAIL areset_hexx got=%h want=0000", bus.disp_hexx); end
    total++; if (bus.disp_points !== 4'h0) begin bad++; $display("FAIL areset_points got=%h want=0", bus.disp_points); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.gnt !== 3'b000 || bus.disp_en !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle gnt=%b en=%b want 000/0", bus.gnt, bus.disp_en);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.req        = 3'b000;
    bus.req_hexx   = {16'hABCD, 16'h2222, 16'h1111};
    bus.req_points = {4'h5, 4'h2, 4'h1};
    bus.max_lum    = 4'd3;
    test_reset();
    test_single_grant();
    test_preempt();
    test_no_lower_preempt();
    test_drop_fade_in();
    test_max_lum();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
